// File: rtl/gpr_param.sv
// Register file with a one-deep write-back stage, sub-word load extension and an overflow flag register.
// Optional feature: define GPR_BYPASS_EN to forward the pending write onto the read ports.
module gpr_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int OVF_REG  = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        regdst,
  input  logic [ADDR_W-1:0] wr1,
  input  logic [ADDR_W-1:0] wr2,
  input  logic [1:0]        write_sel,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] dm_out,
  input  logic [DATA_W-1:0] pc_4,
  input  logic              less,
  input  logic [1:0]        ld_size,
  input  logic              ld_uns,
  input  logic              ovf_set,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] busa,
  output logic [DATA_W-1:0] busb,
  output logic              wb_busy
);

  localparam int Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] OvfAddr  = ADDR_W'(OVF_REG);

  logic [DATA_W-1:0] regs_q [Depth];

  logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
  logic [DATA_W-1:0] pendData_q, pendData_d;
  logic              pendVld_q, pendVld_d;
  logic              pendOvf_q, pendOvf_d;

  logic [DATA_W-1:0] loadExt;
  logic [DATA_W-1:0] srcData;
  logic [ADDR_W-1:0] destAddr;

  always_comb begin
    loadExt = dm_out;
    case (ld_size)
      2'b01:   loadExt = {{(DATA_W-8){dm_out[7] & ~ld_uns}}, dm_out[7:0]};
      2'b10:   loadExt = {{(DATA_W-16){dm_out[15] & ~ld_uns}}, dm_out[15:0]};
      default: loadExt = dm_out;
    endcase
  end

  always_comb begin
    srcData = aluout;
    case (write_sel)
      2'b00:   srcData = aluout;
      2'b01:   srcData = loadExt;
      2'b10:   srcData = pc_4;
      default: srcData = {{(DATA_W-1){1'b0}}, less};
    endcase
  end

  always_comb begin
    destAddr = wr1;
    case (regdst)
      2'b00:   destAddr = wr1;
      2'b01:   destAddr = wr2;
      2'b10:   destAddr = LinkAddr;
      default: destAddr = wr1;
    endcase
  end

  // The stage refills every cycle, so an idle cycle empties it.
  always_comb begin
    pendAddr_d = destAddr;
    pendData_d = srcData;
    pendVld_d  = en && (regdst != 2'b11) && (destAddr != '0);
    pendOvf_d  = en && ovf_set;
  end

  // Overflow commit is ordered last so it wins when both target OVF_REG.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
      pendAddr_q <= '0;
      pendData_q <= '0;
      pendVld_q  <= 1'b0;
      pendOvf_q  <= 1'b0;
    end else begin
      if (pendVld_q) regs_q[pendAddr_q] <= pendData_q;
      if (pendOvf_q) regs_q[OvfAddr] <= DATA_W'(1);
      pendAddr_q <= pendAddr_d;
      pendData_q <= pendData_d;
      pendVld_q  <= pendVld_d;
      pendOvf_q  <= pendOvf_d;
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs_q[addr];
`ifdef GPR_BYPASS_EN
    if (pendVld_q && (pendAddr_q == addr)) val = pendData_q;
    if (pendOvf_q && (addr == OvfAddr)) val = DATA_W'(1);
`endif
    if (addr == '0) val = '0;
    return val;
  endfunction

  always_comb begin
    busa    = readPort(ra);
    busb    = readPort(rb);
    wb_busy = pendVld_q | pendOvf_q;
  end

endmodule

// File: tb/tb_gpr_param.sv
// Self-checking bench for gpr_param: a queue-based write model checked every cycle,
// plus directed literal checks; honours GPR_BYPASS_EN the same way the design does.
module tb_gpr_param;

  logic        clk = 1'b0;
  logic        rst, en, less, ld_uns, ovf_set;
  logic [1:0]  regdst, write_sel, ld_size;
  logic [4:0]  wr1, wr2, ra, rb;
  logic [31:0] aluout, dm_out, pc_4;
  logic [31:0] busa, busb;
  logic        wb_busy;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  gpr_param #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31), .OVF_REG(30)) dut (
    .clk(clk), .rst(rst), .en(en), .regdst(regdst), .wr1(wr1), .wr2(wr2),
    .write_sel(write_sel), .aluout(aluout), .dm_out(dm_out), .pc_4(pc_4),
    .less(less), .ld_size(ld_size), .ld_uns(ld_uns), .ovf_set(ovf_set),
    .ra(ra), .rb(rb), .busa(busa), .busb(busb), .wb_busy(wb_busy)
  );

  always #5 clk = ~clk;

  // Model: committed register values plus the writes that land at the next edge.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] mRegs [32];
  wr_t         mq [$];

  function automatic logic [31:0] srcVal();
    logic [31:0] v;
    case (write_sel)
      2'd0: v = aluout;
      2'd1: begin
        if (ld_size == 2'd1) v = ld_uns ? (dm_out & 32'hFF) : 32'($signed(dm_out[7:0]));
        else if (ld_size == 2'd2) v = ld_uns ? (dm_out & 32'hFFFF) : 32'($signed(dm_out[15:0]));
        else v = dm_out;
      end
      2'd2: v = pc_4;
      default: v = less ? 32'd1 : 32'd0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] addr);
    logic [31:0] v;
    v = mRegs[addr];
`ifdef GPR_BYPASS_EN
    foreach (mq[i]) if (mq[i].a == addr) v = mq[i].d;
`endif
    if (addr == 5'd0) v = 32'd0;
    return v;
  endfunction

  // Later queue entries overwrite earlier ones, so the overflow flag lands last.
  always @(posedge clk) begin
    logic [4:0] dst;
    if (rst) begin
      foreach (mRegs[i]) mRegs[i] = 32'd0;
      mq.delete();
    end else begin
      foreach (mq[i]) mRegs[mq[i].a] = mq[i].d;
      mq.delete();
      if (en) begin
        dst = (regdst == 2'd0) ? wr1 : (regdst == 2'd1) ? wr2 : 5'd31;
        if (regdst != 2'd3 && dst != 5'd0) mq.push_back('{a: dst, d: srcVal()});
        if (ovf_set) mq.push_back('{a: 5'd30, d: 32'd1});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busa", busa, mRead(ra));
      checkOutput("busb", busb, mRead(rb));
      checkOutput("wb_busy", {31'd0, wb_busy}, {31'd0, mq.size() != 0});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one write request through its capture edge; rb tracks the destination.
  task automatic applyStimulus(input logic [1:0] rd, input logic [4:0] a, input logic [1:0] ws,
                               input logic [31:0] v, input logic [1:0] ls, input logic lu,
                               input logic ov);
    regdst = rd; wr1 = a; wr2 = a; rb = a;
    write_sel = ws; aluout = v; dm_out = v; pc_4 = v; less = v[0];
    ld_size = ls; ld_uns = lu; ovf_set = ov; en = 1'b1;
    step();
    en = 1'b0; ovf_set = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [4:0] addr, input logic [31:0] exp);
    ra = addr;
    #1;
    checkOutput(name, busa, exp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; regdst = 2'd0; wr1 = '0; wr2 = '0; write_sel = 2'd0;
    aluout = '0; dm_out = '0; pc_4 = '0; less = 1'b0; ld_size = 2'd0; ld_uns = 1'b0;
    ovf_set = 1'b0; ra = '0; rb = '0;
    step(); step();
    checkEn = 1'b1;
    rst = 1'b0;

    // Random traffic, then a reset with a write still pending.
    for (int i = 0; i < 8; i++) begin
      ra = 5'($urandom_range(0, 31));
      applyStimulus(2'($urandom_range(0, 3)), 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3)),
                    $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end
    applyStimulus(2'd1, 5'd9, 2'd0, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_busy", {31'd0, wb_busy}, 32'd0);
    for (int i = 0; i < 32; i++) readCheck("rst_reg", 5'(i), 32'd0);
    step();

    applyStimulus(2'd1, 5'd5, 2'd0, 32'h0000_1234, 2'd0, 1'b0, 1'b0);
    checkOutput("busy_on", {31'd0, wb_busy}, 32'd1);
    step();
    checkOutput("busy_off", {31'd0, wb_busy}, 32'd0);
    readCheck("reg5", 5'd5, 32'h0000_1234);

    applyStimulus(2'd1, 5'd10, 2'd1, 32'h0000_80F0, 2'd1, 1'b0, 1'b0);
    applyStimulus(2'd0, 5'd11, 2'd1, 32'h0000_80F0, 2'd1, 1'b1, 1'b0);
    applyStimulus(2'd1, 5'd12, 2'd1, 32'h0000_80F0, 2'd2, 1'b0, 1'b0);
    step();
    readCheck("ldb_s", 5'd10, 32'hFFFF_FFF0);
    readCheck("ldb_u", 5'd11, 32'h0000_00F0);
    readCheck("ldh_s", 5'd12, 32'hFFFF_80F0);

    applyStimulus(2'd0, 5'd0, 2'd0, 32'hFFFF_FFFF, 2'd0, 1'b0, 1'b0);
    checkOutput("r0_busy", {31'd0, wb_busy}, 32'd0);
    step();
    readCheck("reg0", 5'd0, 32'd0);

    applyStimulus(2'd1, 5'd7, 2'd0, 32'h0000_0010, 2'd0, 1'b0, 1'b1);
    step();
    readCheck("ovf_r7", 5'd7, 32'h0000_0010);
    readCheck("ovf_r30", 5'd30, 32'd1);
    applyStimulus(2'd1, 5'd30, 2'd0, 32'h0000_0005, 2'd0, 1'b0, 1'b0);
    step();
    readCheck("r30_plain", 5'd30, 32'd5);
    applyStimulus(2'd1, 5'd30, 2'd0, 32'h0000_0055, 2'd0, 1'b0, 1'b1);
    step();
    readCheck("ovf_wins", 5'd30, 32'd1);
    applyStimulus(2'd1, 5'd30, 2'd0, 32'h0000_0005, 2'd0, 1'b0, 1'b0);
    applyStimulus(2'd3, 5'd14, 2'd0, 32'h0000_0099, 2'd0, 1'b0, 1'b1);
    checkOutput("nowr_busy", {31'd0, wb_busy}, 32'd1);
    step();
    readCheck("nowr_r14", 5'd14, 32'd0);
    readCheck("nowr_r30", 5'd30, 32'd1);

    applyStimulus(2'd2, 5'd9, 2'd2, 32'h0000_0400, 2'd0, 1'b0, 1'b0);
    applyStimulus(2'd1, 5'd13, 2'd3, 32'h0000_0001, 2'd0, 1'b0, 1'b0);
    step();
    readCheck("link", 5'd31, 32'h0000_0400);
    readCheck("slt", 5'd13, 32'd1);

    applyStimulus(2'd1, 5'd3, 2'd0, 32'h0000_0011, 2'd0, 1'b0, 1'b0);
    step();
    applyStimulus(2'd1, 5'd3, 2'd0, 32'h0000_00AA, 2'd0, 1'b0, 1'b0);
`ifdef GPR_BYPASS_EN
    readCheck("wr_rd", 5'd3, 32'h0000_00AA);
`else
    readCheck("wr_rd", 5'd3, 32'h0000_0011);
`endif
    step();
    readCheck("wr_rd_late", 5'd3, 32'h0000_00AA);
    applyStimulus(2'd1, 5'd3, 2'd0, 32'h0000_00BB, 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    readCheck("rst_commit", 5'd3, 32'd0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
